// File: rtl/chacha_arbiter.sv
// chacha_arbiter
//
// Purpose: shares a single chacha20_compact core between two requesters.
// Each request carries a 128-bit nonce. The arbiter picks one requester,
// hands its nonce to the core, waits for the core's output block, and returns
// it on the shared result bus with a one-cycle ack to the requester that was
// granted. Ties between the two requesters are broken round-robin. Only one
// transaction is in flight at a time.
//
// Optional feature (macro CHACHA_ARB_TIMEOUT_EN): a watchdog on the WAIT
// state. If the core gives no output within TIMEOUT_CYCLES cycles, the
// transaction is closed with err=1 and result=0. When the macro is not
// defined, WAIT lasts until core_valid, err is tied to 0, and no counter is
// built.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   req0/req1    requests, held high until the matching ack
//   nonce0/1     128-bit nonces, stable while the matching req is high
//   ack0/ack1    one-cycle pulse: result is valid for that requester
//   result       shared result register, held until the next ack
//   err          qualifies ack; 1 means the operation timed out
//   busy         high in every state except IDLE
//   core_start   one-cycle start pulse to the core
//   core_nonce   registered nonce to the core
//   core_ready   core is idle and can accept a start
//   core_valid   core output block is valid
//   core_output  core output block
`timescale 1ns/1ps

module chacha_arbiter #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [127:0] nonce0,
    input  logic         req1,
    input  logic [127:0] nonce1,
    output logic         ack0,
    output logic         ack1,
    output logic [127:0] result,
    output logic         err,
    output logic         busy,
    output logic         core_start,
    output logic [127:0] core_nonce,
    input  logic         core_ready,
    input  logic         core_valid,
    input  logic [127:0] core_output
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t state;
    state_t state_next;
    logic   grant;        // requester that owns the current transaction
    logic   last_grant;   // requester served by the previous transaction
    logic   take;         // a grant is made this cycle if the FSM is in IDLE
    logic   pick;         // requester that would be granted
    logic   timeout_hit;

    // The watchdog counter is 16 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("chacha_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end

    // When both requesters are active, serve the one that was not served last.
    always_comb begin
        take = core_ready && (req0 || req1);
        pick = (req0 && req1) ? ~last_grant : req1;
    end

    always_comb begin
        // NOTE: default first so that no path through the case leaves state_next unassigned (latch).
        state_next = state;
        unique case (state)
            IDLE:    if (take) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (core_valid || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: result and core_nonce are reset as well; they are visible outputs and must read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;    // requester 0 wins the first tie
            core_nonce <= '0;
            result     <= '0;
        end else begin
            if (state == IDLE && take) begin
                grant      <= pick;
                core_nonce <= pick ? nonce1 : nonce0;
            end
            if (state == WAIT) begin
                if (core_valid)       result <= core_output;
                else if (timeout_hit) result <= '0;
            end
            if (state == DONE) last_grant <= grant;
        end
    end

`ifdef CHACHA_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[15:0];

    logic [15:0] wait_cnt;
    logic        err_q;

    // wait_cnt is 0 in the first WAIT cycle. WAIT closes on the cycle after
    // the count reaches the limit, so a timed-out WAIT lasts TIMEOUT_CYCLES+1 cycles.
    assign timeout_hit = (state == WAIT) && !core_valid && (wait_cnt == TIMEOUT_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == ISSUE)                     wait_cnt <= '0;
            else if (state == WAIT && !timeout_hit) wait_cnt <= wait_cnt + 16'd1;
            if (state == WAIT) begin
                if (core_valid)       err_q <= 1'b0;
                else if (timeout_hit) err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    assign busy       = (state != IDLE);
    assign core_start = (state == ISSUE);
    assign ack0       = (state == DONE) && !grant;
    assign ack1       = (state == DONE) &&  grant;

endmodule

// File: doc/chacha_arbiter.md
CHACHA_ARBITER -- requirements
Module: chacha_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096, sets the watchdog limit in clock cycles for one core operation; it is used only when CHACHA_ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single system clock (12 MHz); all logic SHALL be on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req0  input  1  requester 0 request; held high until ack0.
REQ-005 nonce0  input  128  requester 0 challenge/nonce; stable while req0 high.
REQ-006 req1  input  1  requester 1 request; held high until ack1.
REQ-007 nonce1  input  128  requester 1 challenge/nonce; stable while req1 high.
REQ-008 ack0  output  1  one-cycle pulse: result valid for requester 0.
REQ-009 ack1  output  1  one-cycle pulse: result valid for requester 1.
REQ-010 result  output  128  shared result register, valid in the ack cycle and held until the next ack.
REQ-011 err  output  1  qualifies ack: 1 means the operation timed out.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 core_start  output  1  one-cycle start pulse to the chacha20_compact core.
REQ-014 core_nonce  output  128  nonce to the core, registered, stable from ISSUE through WAIT.
REQ-015 core_ready  input  1  core idle and able to accept start.
REQ-016 core_valid  input  1  core output_block valid (pulse or level).
REQ-017 core_output  input  128  core output_block.

Function
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-019 IDLE: when core_ready=1 and req0|req1, the block SHALL select one requester, latch its nonce into core_nonce, record it as grant, and move to ISSUE; otherwise it SHALL stay in IDLE.
REQ-020 Arbitration: a lone requester SHALL be selected; when both request, the block SHALL select the requester not recorded in last_grant (round-robin).
REQ-021 last_grant SHALL update only in DONE.
REQ-022 ISSUE: core_start SHALL be 1 for exactly this one cycle, then the FSM SHALL go to WAIT.
REQ-023 WAIT: core_valid sampled high SHALL load core_output into result, set err=0 and move to DONE; core_valid outside WAIT SHALL be ignored.
REQ-024 DONE: ack[grant]=1 for one cycle with the other ack at 0, then the FSM SHALL go to IDLE.
REQ-025 Latency: a request sampled in IDLE at edge k SHALL give core_start high in cycle k+1.
REQ-026 Latency: core_valid sampled at edge m SHALL give ack and result in cycle m+1.
REQ-027 The earliest next grant SHALL be the cycle after DONE, i.e. one idle cycle between transactions.
REQ-028 A req deasserted before grant SHALL be ignored.
REQ-029 A req deasserted after grant SHALL not abort the transaction; ack SHALL still pulse.
REQ-030 If core_ready=0 in IDLE, no grant SHALL occur and requests SHALL stay pending without loss.
REQ-031 ack0 and ack1 SHALL never be high in the same cycle, and at most one transaction SHALL be outstanding.
REQ-032 The block SHALL have no internal buffering of nonces beyond core_nonce.

Reset
REQ-033 While rst=1: state=IDLE, last_grant=1 (so requester 0 wins the first tie), core_start=0, ack0=ack1=0, err=0, busy=0, result=0 and core_nonce=0.
REQ-034 rst asserted mid-transaction SHALL abandon it with no ack; a core_valid arriving after reset release SHALL be ignored because the FSM is in IDLE.

Configuration
REQ-035 With CHACHA_ARB_TIMEOUT_EN defined, a 16-bit cycle counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-036 With CHACHA_ARB_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without core_valid SHALL force DONE with err=1 and result=0.
REQ-037 Without CHACHA_ARB_TIMEOUT_EN, WAIT SHALL last until core_valid, err SHALL be tied 0, and no counter logic SHALL exist.

Verification
REQ-038 Single request: req0=1, nonce0=128'h0123...CDEF, core_ready=1 -> core_start in cycle 1; core_valid with core_output=128'hDEADBEEF... at edge m -> ack0=1, result=128'hDEADBEEF..., err=0 at m+1.
REQ-039 Tie after reset: req0=req1=1 -> grants alternate 0,1,0,1 over four transactions, each core_nonce matching the granted nonce.
REQ-040 Core busy: core_ready=0 for 20 cycles with req1=1 -> no core_start; core_ready=1 -> core_start next cycle with nonce1.
REQ-041 Reset mid-WAIT: rst pulsed in WAIT, then core_valid -> no ack; state IDLE; all outputs at reset values.
REQ-042 Timeout (macro on, TIMEOUT_CYCLES=16): no core_valid -> ack0=1, err=1, result=0 exactly 17 cycles after WAIT entry.
REQ-043 Early drop: req1 pulsed for one cycle while busy with requester 0 -> never granted and ack1 never pulses.
